pipeline_ctrl: RTL and testbench

Central pipeline controller for the 5-stage core. It merges stall requests from ID/EX/MEM into the per-stage stall vector consumed by the PC register and the inter-stage registers. On an exception or ERET it issues the flush pulse and redirect address (new_pc). It sequences a post-flush refill window and keeps a stall performance counter.

---
 rtl/pipeline_ctrl_if.sv | 26 ++
 rtl/pipeline_ctrl.sv | 114 +++++++++++
 tb/tb_pipeline_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Bundle of stall requests, exception inputs and control outputs exchanged
// between the pipeline stages and pipeline_ctrl.
interface pipeline_ctrl_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic        clr_cnt;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        busy;
    logic [31:0] stall_cnt;
    logic        wdog_timeout;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i, clr_cnt,
        input  stall, flush, new_pc, busy, stall_cnt, wdog_timeout
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i, clr_cnt,
        output stall, flush, new_pc, busy, stall_cnt, wdog_timeout
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with post-flush refill window and stall counter.
// Optional MEM-stall watchdog enabled by defining STALL_WATCHDOG_EN.
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned WDOG_LIMIT   = 1023
) (
    input logic            clk,
    input logic            rst,
    pipeline_ctrl_if.slave bus
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [31:0] ERET_CODE   = 32'h0000000e;
    localparam logic [3:0]  REFILL_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  refill_q, refill_d;
    logic [31:0] stall_cnt_q;
    logic [5:0]  stall_req;

    always_comb begin
        stall_req = '0;
        if (bus.stallreq_mem)     stall_req = 6'b011111;
        else if (bus.stallreq_ex) stall_req = 6'b001111;
        else if (bus.stallreq_id) stall_req = 6'b000111;
    end

    always_comb begin
        state_d    = state_q;
        refill_d   = refill_q;
        bus.stall  = '0;
        bus.flush  = 1'b0;
        bus.new_pc = '0;
        bus.busy   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.excepttype_i != '0) begin
                    bus.flush  = 1'b1;
                    bus.new_pc = (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
                    state_d    = FLUSH;
                    refill_d   = REFILL_INIT;
                end else begin
                    bus.stall = stall_req;
                end
            end
            FLUSH: begin
                bus.busy  = 1'b1;
                bus.stall = stall_req;
                // Refill window only advances on cycles where the PC actually moves
                if (!stall_req[0]) begin
                    if (refill_q == '0) state_d = RUN;
                    else                refill_d = refill_q - 4'd1;
                end
            end
        endcase
        if (!rst) begin
            bus.stall  = '0;
            bus.flush  = 1'b0;
            bus.new_pc = '0;
            bus.busy   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            refill_q <= '0;
        end else begin
            state_q  <= state_d;
            refill_q <= refill_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (bus.clr_cnt) begin
            stall_cnt_q <= '0;
        end else if (bus.stall[0] && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;

`ifdef STALL_WATCHDOG_EN
    localparam logic [15:0] WDOG_MAX = 16'(WDOG_LIMIT);

    logic [15:0] wdog_cnt_q;
    logic        wdog_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt_q <= '0;
            wdog_q     <= 1'b0;
        end else if (bus.clr_cnt) begin
            wdog_cnt_q <= '0;
            wdog_q     <= 1'b0;
        end else if (!bus.stallreq_mem) begin
            wdog_cnt_q <= '0;
        end else if (wdog_cnt_q != WDOG_MAX) begin
            wdog_cnt_q <= wdog_cnt_q + 16'd1;
            if (wdog_cnt_q + 16'd1 == WDOG_MAX) wdog_q <= 1'b1;
        end
    end

    assign bus.wdog_timeout = wdog_q;
`else
    assign bus.wdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl: per-cycle comparison against a
// behavioural model, plus hand-computed literal checks.
module tb_pipeline_ctrl;

    localparam logic [31:0] EXC_VEC = 32'h00000020;
    localparam int          FLUSH_N = 2;
    localparam int          WD_LIM  = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(
        .EXC_VECTOR  (EXC_VEC),
        .FLUSH_CYCLES(FLUSH_N),
        .WDOG_LIMIT  (WD_LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: refill window tracked as a number of remaining unstalled cycles.
    logic   m_busy;
    int     m_left;
    longint m_cnt;
    int     m_run;
    logic   m_wdog;

    always @(negedge clk) begin
        logic        take;
        logic [5:0]  req;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        if (!rst) begin
            m_busy = 1'b0; m_left = 0; m_cnt = 0; m_run = 0; m_wdog = 1'b0;
        end
        req = bus.stallreq_mem ? 6'h1f : bus.stallreq_ex ? 6'h0f : bus.stallreq_id ? 6'h07 : 6'h00;
        take    = rst && !m_busy && (bus.excepttype_i != 0);
        e_stall = (!rst || take) ? 6'h00 : req;
        e_flush = take;
        e_pc    = !take ? 32'h0 : (bus.excepttype_i == 32'he) ? bus.cp0_epc_i : EXC_VEC;
        check("stall", 32'(bus.stall), 32'(e_stall));
        check("flush", 32'(bus.flush), 32'(e_flush));
        check("new_pc", bus.new_pc, e_pc);
        check("busy", 32'(bus.busy), 32'(m_busy && rst));
        check("stall_cnt", bus.stall_cnt, m_cnt[31:0]);
        check("wdog", 32'(bus.wdog_timeout), 32'(m_wdog));
        if (rst) begin
            if (bus.clr_cnt) m_cnt = 0;
            else if (e_stall[0] && m_cnt < 64'hFFFFFFFF) m_cnt++;
            if (take) begin
                m_busy = 1'b1; m_left = FLUSH_N;
            end else if (m_busy && !e_stall[0]) begin
                m_left--;
                if (m_left == 0) m_busy = 1'b0;
            end
`ifdef STALL_WATCHDOG_EN
            if (bus.clr_cnt) begin
                m_run = 0; m_wdog = 1'b0;
            end else if (!bus.stallreq_mem) begin
                m_run = 0;
            end else if (m_run < WD_LIM) begin
                m_run++;
                if (m_run == WD_LIM) m_wdog = 1'b1;
            end
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.stallreq_id = 1'b0; bus.stallreq_ex = 1'b0; bus.stallreq_mem = 1'b0;
        bus.excepttype_i = '0;  bus.clr_cnt = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        clear_reqs();
        bus.cp0_epc_i = '0;
        repeat (3) step();
        @(negedge clk);
        check("reset_cnt", bus.stall_cnt, 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        step();

        // Priority: EX beats ID, MEM beats EX
        rst = 1'b1;
        bus.stallreq_id = 1'b1; bus.stallreq_ex = 1'b1;
        @(negedge clk);
        check("prio_ex", 32'(bus.stall), 32'h0f);
        step(); step();
        bus.stallreq_mem = 1'b1;
        @(negedge clk);
        check("prio_mem", 32'(bus.stall), 32'h1f);
        repeat (3) step();
        @(negedge clk);
        check("cnt_held", bus.stall_cnt, 32'd5);
        step();

        // Exception overrides MEM stall
        bus.excepttype_i = 32'h8;
        @(negedge clk);
        check("exc_flush", 32'(bus.flush), 32'h1);
        check("exc_stall", 32'(bus.stall), 32'h0);
        check("exc_pc", bus.new_pc, 32'h20);
        step();
        clear_reqs();
        @(negedge clk);
        check("post_flush", 32'(bus.flush), 32'h0);
        check("refill_a", 32'(bus.busy), 32'h1);
        step();
        @(negedge clk);
        check("refill_b", 32'(bus.busy), 32'h1);
        step();
        @(negedge clk);
        check("refill_done", 32'(bus.busy), 32'h0);
        check("cnt_no_flush", bus.stall_cnt, 32'd6);
        step();

        // ERET, then exception ignored and EX stall during refill
        bus.excepttype_i = 32'he; bus.cp0_epc_i = 32'h00001234;
        @(negedge clk);
        check("eret_pc", bus.new_pc, 32'h00001234);
        check("eret_flush", 32'(bus.flush), 32'h1);
        step();
        bus.excepttype_i = 32'ha; bus.stallreq_ex = 1'b1;
        @(negedge clk);
        check("flush_ignored", 32'(bus.flush), 32'h0);
        repeat (3) step();
        clear_reqs();
        step();
        @(negedge clk);
        check("ext_busy", 32'(bus.busy), 32'h1);
        step();
        @(negedge clk);
        check("ext_done", 32'(bus.busy), 32'h0);
        step();

        // Saturation and clear-over-increment
        bus.stallreq_mem = 1'b1;
        force dut.stall_cnt_q = 32'hFFFFFFFD;
        m_cnt = 64'hFFFFFFFD;
        #1 release dut.stall_cnt_q;
        repeat (4) step();
        @(negedge clk);
        check("saturate", bus.stall_cnt, 32'hFFFFFFFF);
        step();
        bus.clr_cnt = 1'b1;
        step();
        bus.clr_cnt = 1'b0; bus.stallreq_mem = 1'b0;
        @(negedge clk);
        check("clear_wins", bus.stall_cnt, 32'h0);
        step();

        // Reset in the middle of the refill window
        bus.excepttype_i = 32'h8;
        step();
        rst = 1'b0; bus.stallreq_id = 1'b1; bus.stallreq_ex = 1'b1;
        @(negedge clk);
        check("rst_stall", 32'(bus.stall), 32'h0);
        check("rst_flush", 32'(bus.flush), 32'h0);
        check("rst_pc", bus.new_pc, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        step();
        rst = 1'b1;
        clear_reqs();
        @(negedge clk);
        check("no_reissue", 32'(bus.flush), 32'h0);
        check("rst_run", 32'(bus.busy), 32'h0);
        step();

        // Watchdog: interrupted run does not trip, full run trips and sticks
        bus.stallreq_mem = 1'b1;
        repeat (4) step();
        bus.stallreq_mem = 1'b0;
        step();
        bus.stallreq_mem = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("wdog_pulse", 32'(bus.wdog_timeout), 32'h0);
        step();
        bus.stallreq_mem = 1'b0;
        step();
        bus.stallreq_mem = 1'b1;
        repeat (7) step();
        @(negedge clk);
        check("wdog_7", 32'(bus.wdog_timeout), 32'h0);
        step();
        bus.stallreq_mem = 1'b0;
        @(negedge clk);
`ifdef STALL_WATCHDOG_EN
        check("wdog_trip", 32'(bus.wdog_timeout), 32'h1);
`else
        check("wdog_off", 32'(bus.wdog_timeout), 32'h0);
`endif
        repeat (2) step();
        bus.clr_cnt = 1'b1;
        step();
        bus.clr_cnt = 1'b0;
        @(negedge clk);
        check("wdog_clr", 32'(bus.wdog_timeout), 32'h0);
        repeat (2) step();

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
